// File: rtl/video_timing_pattern_gen.sv
// video_timing_pattern_gen
//   Pixel-clock video timing generator with a selectable test-pattern source.
//   It produces DVI/HDMI-style hs/vs/de/rgb for any resolution described by
//   the porch, sync and active parameters. It also produces pixel coordinates
//   and frame/line strobes. Each axis runs back porch, active, front porch,
//   then sync.
//
// Ports
//   clk_pixel   in   1    pixel clock
//   rst         in   1    asynchronous reset, active-high
//   enable      in   1    run; low holds the counters at 0 (e.g. pll_locked)
//   mode        in   3    0 solid, 1 wipe, 2 colour bars, 3 checker,
//                         4 gradient, 5-7 black
//   rgb_hs      out  1    horizontal sync, H_POLAR when asserted
//   rgb_vs      out  1    vertical sync, V_POLAR when asserted
//   rgb_de      out  1    data enable
//   rgb_data    out  24   {r,g,b}; 0 whenever rgb_de is low
//   pix_x       out  CW   active x coordinate, valid when rgb_de
//   pix_y       out  CW   active y coordinate, valid when rgb_de
//   frame_start out  1    pulse on the first output cycle of each frame
//   line_start  out  1    pulse on the first output cycle of each line
module video_timing_pattern_gen #(
  parameter int          H_BPORCH   = 220,
  parameter int          H_ACTIVE   = 1280,
  parameter int          H_FPORCH   = 110,
  parameter int          H_SYNC     = 40,
  parameter logic        H_POLAR    = 1'b1,
  parameter int          V_BPORCH   = 20,
  parameter int          V_ACTIVE   = 720,
  parameter int          V_FPORCH   = 5,
  parameter int          V_SYNC     = 5,
  parameter logic        V_POLAR    = 1'b1,
  parameter int          CW         = 12,
  parameter int          WIPE_STEP  = 720,
  parameter int          CHECK_LOG2 = 5,
  parameter logic [23:0] FG_RGB     = 24'h00BBBB
) (
  input  logic          clk_pixel,
  input  logic          rst,
  input  logic          enable,
  input  logic [2:0]    mode,
  output logic          rgb_hs,
  output logic          rgb_vs,
  output logic          rgb_de,
  output logic [23:0]   rgb_data,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          frame_start,
  output logic          line_start
);

  localparam logic [CW-1:0] H_ACT_BEG = CW'(H_BPORCH);
  localparam logic [CW-1:0] H_ACT_END = CW'(H_BPORCH + H_ACTIVE);
  localparam logic [CW-1:0] H_SYN_BEG = CW'(H_BPORCH + H_ACTIVE + H_FPORCH);
  localparam logic [CW-1:0] H_LAST    = CW'(H_BPORCH + H_ACTIVE + H_FPORCH + H_SYNC - 1);
  localparam logic [CW-1:0] V_ACT_BEG = CW'(V_BPORCH);
  localparam logic [CW-1:0] V_ACT_END = CW'(V_BPORCH + V_ACTIVE);
  localparam logic [CW-1:0] V_SYN_BEG = CW'(V_BPORCH + V_ACTIVE + V_FPORCH);
  localparam logic [CW-1:0] V_LAST    = CW'(V_BPORCH + V_ACTIVE + V_FPORCH + V_SYNC - 1);
  localparam logic [CW-1:0] BAR_LAST  = CW'(H_ACTIVE / 8 - 1);
  localparam logic [23:0]   WIPE_LAST = 24'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [23:0]   WIPE_INC  = 24'(WIPE_STEP);
  localparam logic [23:0]   WHITE     = 24'hFFFFFF;

  logic [CW-1:0] cnt_h;
  logic [CW-1:0] cnt_v;
  logic          run;
  logic [2:0]    mode_q;
  logic [23:0]   wipe_pos;
  logic [23:0]   de_cnt;
  logic [CW-1:0] bar_cnt;
  logic [2:0]    bar_idx;

  logic          active;
  logic          h_sync;
  logic          v_sync;
  logic          at_origin;
  logic          at_line;
  logic [2:0]    mode_eff;
  logic [CW-1:0] px;
  logic [CW-1:0] py;
  logic [23:0]   bar_rgb;
  logic [23:0]   pattern;

  // Decode of the current counter state. 'run' qualifies the strobes, so a
  // held (disabled) generator sitting at (0,0) does not fire them every cycle.
  // At the origin the live mode input is used because mode_q only picks it
  // up on this same edge.
  always_comb begin
    active    = (cnt_h >= H_ACT_BEG) && (cnt_h < H_ACT_END) &&
                (cnt_v >= V_ACT_BEG) && (cnt_v < V_ACT_END);
    h_sync    = (cnt_h >= H_SYN_BEG);
    v_sync    = (cnt_v >= V_SYN_BEG);
    at_line   = run && (cnt_h == '0);
    at_origin = at_line && (cnt_v == '0);
    mode_eff  = at_origin ? mode : mode_q;
    px        = cnt_h - H_ACT_BEG;
    py        = cnt_v - V_ACT_BEG;
  end

  // Raster counters. On the first enabled edge after reset or a hold, the
  // counters stay at (0,0) and only 'run' rises. This ensures the origin is
  // presented once with run high, which is what fires frame_start on restart.
  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      cnt_h <= '0;
      cnt_v <= '0;
      run   <= 1'b0;
    end else if (!enable) begin
      cnt_h <= '0;
      cnt_v <= '0;
      run   <= 1'b0;
    end else if (!run) begin
      run <= 1'b1;
    end else if (cnt_h == H_LAST) begin
      cnt_h <= '0;
      cnt_v <= (cnt_v == V_LAST) ? '0 : cnt_v + CW'(1);
    end else begin
      cnt_h <= cnt_h + CW'(1);
    end
  end

  // Per-frame state, updated only at the origin: the pattern selection and
  // the wipe boundary. The wipe boundary advances regardless of mode.
  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      mode_q   <= 3'd0;
      wipe_pos <= '0;
    end else if (at_origin) begin
      mode_q   <= mode;
      wipe_pos <= (wipe_pos >= WIPE_LAST) ? '0 : wipe_pos + WIPE_INC;
    end
  end

  // Running pixel index and colour-bar position. These avoid a multiplier
  // and a divider. de_cnt counts active pixels already emitted this frame, so
  // it equals y*H_ACTIVE+x for the current pixel. bar_cnt/bar_idx walk the
  // eight bars across each active line and fall back to 0 in blanking.
  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      de_cnt  <= '0;
      bar_cnt <= '0;
      bar_idx <= 3'd0;
    end else if (!enable || !run) begin
      de_cnt  <= '0;
      bar_cnt <= '0;
      bar_idx <= 3'd0;
    end else begin
      if (v_sync) begin
        de_cnt <= '0;
      end else if (active) begin
        de_cnt <= de_cnt + 24'd1;
      end
      if (!active) begin
        bar_cnt <= '0;
        bar_idx <= 3'd0;
      end else if (bar_cnt == BAR_LAST) begin
        bar_cnt <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_cnt <= bar_cnt + CW'(1);
      end
    end
  end

  // Colour of the current bar, left to right.
  always_comb begin
    bar_rgb = 24'h000000;
    case (bar_idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  end

  // Pattern mux for the current pixel; blanking is applied at the register.
  always_comb begin
    pattern = 24'h000000;
    case (mode_eff)
      3'd0:    pattern = FG_RGB;
      3'd1:    pattern = (de_cnt < wipe_pos) ? WHITE : FG_RGB;
      3'd2:    pattern = bar_rgb;
      3'd3:    pattern = (px[CHECK_LOG2] ^ py[CHECK_LOG2]) ? WHITE : 24'h000000;
      3'd4:    pattern = {px[7:0], py[7:0], 8'h80};
      default: pattern = 24'h000000;
    endcase
  end

  // Output register. Every output is taken from the same counter state, so
  // all outputs lag the counters by exactly one clock and stay aligned.
  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      rgb_hs      <= ~H_POLAR;
      rgb_vs      <= ~V_POLAR;
      rgb_de      <= 1'b0;
      rgb_data    <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      rgb_hs      <= h_sync ? H_POLAR : ~H_POLAR;
      rgb_vs      <= v_sync ? V_POLAR : ~V_POLAR;
      rgb_de      <= active;
      rgb_data    <= active ? pattern : 24'h000000;
      pix_x       <= px;
      pix_y       <= py;
      frame_start <= at_origin;
      line_start  <= at_line;
    end
  end

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// tb_video_timing_pattern_gen
//   Scoreboard bench for video_timing_pattern_gen using a small raster:
//   H 2/16/2/2 (22 clk per line) and V 1/4/1/1 (7 lines, 154 clk per frame).
//   Each active frame holds 16x4 pixels. The stimulus process pushes each
//   frame's expected pixels as soon as that frame's frame_start appears. The
//   monitor pops one entry on every rgb_de cycle. It also checks the
//   line/frame timing of undisturbed frames.
module tb_video_timing_pattern_gen;

  localparam int          CW = 12;
  localparam logic [23:0] FG = 24'h00BBBB;

  logic          clk_pixel = 1'b0;
  logic          rst;
  logic          enable;
  logic [2:0]    mode;
  logic          rgb_hs;
  logic          rgb_vs;
  logic          rgb_de;
  logic [23:0]   rgb_data;
  logic [CW-1:0] pix_x;
  logic [CW-1:0] pix_y;
  logic          frame_start;
  logic          line_start;

  video_timing_pattern_gen #(
    .H_BPORCH(2), .H_ACTIVE(16), .H_FPORCH(2), .H_SYNC(2), .H_POLAR(1'b1),
    .V_BPORCH(1), .V_ACTIVE(4), .V_FPORCH(1), .V_SYNC(1), .V_POLAR(1'b1),
    .CW(CW), .WIPE_STEP(16), .CHECK_LOG2(1), .FG_RGB(FG)
  ) dut (
    .clk_pixel(clk_pixel), .rst(rst), .enable(enable), .mode(mode),
    .rgb_hs(rgb_hs), .rgb_vs(rgb_vs), .rgb_de(rgb_de), .rgb_data(rgb_data),
    .pix_x(pix_x), .pix_y(pix_y),
    .frame_start(frame_start), .line_start(line_start)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [23:0]   rgb;
  } pix_t;

  pix_t exp_q[$];
  int   assertions = 0;
  int   failures   = 0;
  int   wipe_model = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference colour for one active pixel, derived from the pattern rules.
  function automatic logic [23:0] expRgb(input int m, input int x, input int y, input int wipe);
    logic [23:0] c;
    logic [7:0]  xb;
    logic [7:0]  yb;
    xb = 8'(x);
    yb = 8'(y);
    case (m)
      0: c = FG;
      1: c = ((y * 16 + x) < wipe) ? 24'hFFFFFF : FG;
      2: case (x / 2)
           0: c = 24'hFFFFFF;
           1: c = 24'hFFFF00;
           2: c = 24'h00FFFF;
           3: c = 24'h00FF00;
           4: c = 24'hFF00FF;
           5: c = 24'hFF0000;
           6: c = 24'h0000FF;
           default: c = 24'h000000;
         endcase
      3: c = (((x / 2) % 2) != ((y / 2) % 2)) ? 24'hFFFFFF : 24'h000000;
      4: c = {xb, yb, 8'h80};
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  // Wait for the next frame_start, then queue that frame's 64 pixels using
  // the mode that was latched at its origin. Afterwards, select the mode for
  // the following frame.
  task automatic applyStimulus(input logic [2:0] next_mode, output int latency);
    int n;
    n = 0;
    do begin
      @(negedge clk_pixel);
      n++;
    end while (!frame_start && n < 400);
    latency = n;
    if (!frame_start) begin
      assertions++;
      failures++;
      $display("[TB] FAIL frame_start timeout: got none in %0d clk, required a pulse", n);
    end else begin
      wipe_model = (wipe_model >= 63) ? 0 : wipe_model + 16;
      for (int y = 0; y < 4; y++) begin
        for (int x = 0; x < 16; x++) begin
          exp_q.push_back('{x: CW'(x), y: CW'(y), rgb: expRgb(int'(mode), x, y, wipe_model)});
        end
      end
    end
    mode = next_mode;
  endtask

  // Monitor: pixel scoreboard plus per-line/per-frame timing statistics.
  // Statistics are discarded whenever reset or a hold interrupts a frame.
  int f_len = 0, f_de = 0, f_vs = 0, f_ls = 0, vs_first = -1;
  int l_len = 0, l_hs = 0, hs_first = -1;
  bit f_valid = 1'b0, l_valid = 1'b0;

  always @(negedge clk_pixel) begin
    pix_t e;
    if (rgb_de) begin
      if (exp_q.size() == 0) begin
        assertions++;
        failures++;
        $display("[TB] FAIL unexpected pixel: got x=%0d y=%0d rgb=%0h, expected no active pixel",
                 pix_x, pix_y, rgb_data);
      end else begin
        e = exp_q.pop_front();
        checkOutput("pixel {x,y,rgb}", {pix_x, pix_y, rgb_data}, {e.x, e.y, e.rgb});
      end
    end else begin
      checkOutput("rgb blank", rgb_data, 0);
    end

    if (rst || !enable) begin
      f_valid = 1'b0;
      l_valid = 1'b0;
    end else begin
      if (frame_start) begin
        if (f_valid) begin
          checkOutput("frame length", f_len, 154);
          checkOutput("de per frame", f_de, 64);
          checkOutput("vs width", f_vs, 22);
          checkOutput("vs start", vs_first, 132);
          checkOutput("lines per frame", f_ls, 7);
        end
        f_len = 0; f_de = 0; f_vs = 0; f_ls = 0; vs_first = -1;
        f_valid = 1'b1;
      end
      if (line_start) begin
        if (l_valid) begin
          checkOutput("line length", l_len, 22);
          checkOutput("hs width", l_hs, 2);
          checkOutput("hs start", hs_first, 20);
        end
        l_len = 0; l_hs = 0; hs_first = -1;
        l_valid = 1'b1;
      end
      if (rgb_hs && l_hs == 0) hs_first = l_len;
      if (rgb_hs) l_hs++;
      if (rgb_vs && f_vs == 0) vs_first = f_len;
      if (rgb_vs) f_vs++;
      if (rgb_de) f_de++;
      if (line_start) f_ls++;
      f_len++;
      l_len++;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time exhausted, required normal completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [2:0] next_modes [8];
    int lat;
    next_modes = '{3'd2, 3'd1, 3'd1, 3'd1, 3'd3, 3'd4, 3'd5, 3'd0};

    rst    = 1'b1;
    enable = 1'b1;
    mode   = 3'd0;
    repeat (3) @(negedge clk_pixel);
    checkOutput("reset hs", rgb_hs, 0);
    checkOutput("reset vs", rgb_vs, 0);
    checkOutput("reset de/strobes", {rgb_de, frame_start, line_start}, 0);
    checkOutput("reset rgb/pix", {rgb_data, pix_x, pix_y}, 0);

    #2 rst = 1'b0;
    $display("[TB] reset released, running pattern frames");

    // Frame 1 is solid. Frames 2..9 are wipe, bars, wipe (full), wipe (none),
    // wipe, checker, gradient and black.
    applyStimulus(3'd1, lat);
    checkOutput("first frame latency", lat, 2);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(next_modes[i], lat);
      checkOutput("frame period", lat, 154);
    end

    // Frame 10: solid. Mode switches to checker at line 3 and must only take
    // effect on frame 11.
    applyStimulus(3'd0, lat);
    checkOutput("frame period", lat, 154);
    repeat (71) @(negedge clk_pixel);
    mode = 3'd3;
    applyStimulus(3'd3, lat);
    checkOutput("frame period after mode change", lat, 83);

    // Frame 11: hold enable low for 10 clk in the front-porch line.
    repeat (115) @(negedge clk_pixel);
    enable = 1'b0;
    mode   = 3'd6;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_pixel);
      checkOutput("held de/fs/ls", {rgb_de, frame_start, line_start}, 0);
      checkOutput("held hs/vs", {rgb_hs, rgb_vs}, 0);
    end
    enable = 1'b1;
    applyStimulus(3'd6, lat);
    checkOutput("resume frame_start latency", lat, 2);

    // Frame 12 (black): reset pulse in the middle of the sync portion of line 5.
    repeat (130) @(negedge clk_pixel);
    checkOutput("hs before reset", rgb_hs, 1);
    checkOutput("pix before reset", {pix_x, pix_y}, {12'd18, 12'd4});
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset hs/vs/de", {rgb_hs, rgb_vs, rgb_de}, 0);
    checkOutput("async reset rgb/pix", {rgb_data, pix_x, pix_y}, 0);
    checkOutput("async reset strobes", {frame_start, line_start}, 0);
    wipe_model = 0;
    mode = 3'd1;
    repeat (3) @(negedge clk_pixel);
    #2 rst = 1'b0;
    applyStimulus(3'd2, lat);
    checkOutput("post-reset frame latency", lat, 2);
    applyStimulus(3'd2, lat);
    checkOutput("frame period", lat, 154);

    // Stop the raster once the last frame's pixels have been consumed.
    repeat (115) @(negedge clk_pixel);
    enable = 1'b0;
    repeat (5) @(negedge clk_pixel);
    checkOutput("scoreboard drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
